// File: rtl/ram_1rw1r_model.sv
// Behavioural SRAM: port 0 read/write with lane mask, port 1 read-only.
// Both ports return {vld, err, data} through a READ_LAT-deep pipeline; collisions are flagged.

module ram_1rw1r_rd_pipe #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LAT        = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  vld_i,
  input  logic                  err_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  vld_o,
  output logic                  err_o,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic [LAT-1:0]                 vld_q, vld_d;
  logic [LAT-1:0]                 err_q, err_d;
  logic [LAT-1:0][DATA_WIDTH-1:0] data_q, data_d;

  // Data only advances with a valid, so the last stage holds between results.
  for (genvar g = 0; g < LAT; g++) begin : g_stage
    if (g == 0) begin : g_head
      assign vld_d[g]  = vld_i;
      assign err_d[g]  = err_i;
      assign data_d[g] = vld_i ? data_i : data_q[g];
    end else begin : g_tail
      assign vld_d[g]  = vld_q[g-1];
      assign err_d[g]  = err_q[g-1];
      assign data_d[g] = vld_q[g-1] ? data_q[g-1] : data_q[g];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q  <= '0;
      err_q  <= '0;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      err_q  <= err_d;
      data_q <= data_d;
    end
  end

  assign vld_o  = vld_q[LAT-1];
  assign err_o  = err_q[LAT-1];
  assign data_o = data_q[LAT-1];

endmodule

module ram_1rw1r_model #(
  parameter  int unsigned DATA_WIDTH = 32,
  parameter  int unsigned ADDR_WIDTH = 8,
  parameter  int unsigned DEPTH      = 256,
  parameter  int unsigned WMASK_GRAN = 8,
  parameter  int unsigned READ_LAT   = 1,
  parameter  int unsigned RDW_MODE   = 0,
  localparam int unsigned WMASK_W    = DATA_WIDTH / WMASK_GRAN
) (
  input  logic                  clk0,
  input  logic                  rst0,
  input  logic                  cs0,
  input  logic                  we0,
  input  logic [WMASK_W-1:0]    wmask0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] din0,
  output logic [DATA_WIDTH-1:0] dout0,
  output logic                  dout0_vld,
  output logic                  err0,
  input  logic                  cs1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic [DATA_WIDTH-1:0] dout1,
  output logic                  dout1_vld,
  output logic                  err1,
  output logic                  collision
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned AW1   = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_A = AW1'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  in0_c, in1_c;
  logic [IDX_W-1:0]      idx0_c, idx1_c;
  logic                  wr0_c, rd0_c, oor0_c, oor1_c, coll_c;
  logic [DATA_WIDTH-1:0] word0_c, word1_c, merged_c, rword0_c, rword1_c;
  logic                  coll_q;

  assign in0_c  = ({1'b0, addr0} < DEPTH_A);
  assign in1_c  = ({1'b0, addr1} < DEPTH_A);
  assign idx0_c = IDX_W'(addr0);
  assign idx1_c = IDX_W'(addr1);

  assign wr0_c  = cs0 & we0 & in0_c;
  assign rd0_c  = cs0 & ~we0;
  assign oor0_c = cs0 & ~in0_c;
  assign oor1_c = cs1 & ~in1_c;
  assign coll_c = wr0_c & cs1 & (addr0 == addr1);

  assign word0_c = mem_q[idx0_c];
  assign word1_c = mem_q[idx1_c];

  // Lane merge of the port-0 write into the currently stored word.
  for (genvar g = 0; g < WMASK_W; g++) begin : g_lane
    assign merged_c[g*WMASK_GRAN +: WMASK_GRAN] =
      wmask0[g] ? din0[g*WMASK_GRAN +: WMASK_GRAN] : word0_c[g*WMASK_GRAN +: WMASK_GRAN];
  end

  assign rword0_c = in0_c ? word0_c : '0;

  always_comb begin
    rword1_c = '0;
    if (in1_c) begin
      rword1_c = word1_c;
      if ((RDW_MODE == 1) && coll_c) rword1_c = merged_c;
    end
  end

  // Array contents survive reset; accesses under reset are ignored.
  always_ff @(posedge clk0) begin
    if (!rst0 && wr0_c) mem_q[idx0_c] <= merged_c;
  end

  always_ff @(posedge clk0) begin
    if (rst0) coll_q <= 1'b0;
    else      coll_q <= coll_c;
  end

  assign collision = coll_q;

  ram_1rw1r_rd_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .LAT        (READ_LAT)
  ) u_pipe0 (
    .clk_i  (clk0),
    .rst_i  (rst0),
    .vld_i  (rd0_c),
    .err_i  (oor0_c),
    .data_i (rword0_c),
    .vld_o  (dout0_vld),
    .err_o  (err0),
    .data_o (dout0)
  );

  ram_1rw1r_rd_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .LAT        (READ_LAT)
  ) u_pipe1 (
    .clk_i  (clk0),
    .rst_i  (rst0),
    .vld_i  (cs1),
    .err_i  (oor1_c),
    .data_i (rword1_c),
    .vld_o  (dout1_vld),
    .err_o  (err1),
    .data_o (dout1)
  );

endmodule

// File: tb/tb_ram_1rw1r_model.sv
// Scoreboard bench: instance A (DEPTH=200, READ_LAT=3, old-data RDW) and
// instance B (DEPTH=256, READ_LAT=1, new-data RDW).
module tb_ram_1rw1r_model;

  localparam int LAT_A = 3;
  localparam int LAT_B = 1;

  typedef struct {
    int          cyc;
    logic        vld;
    logic        err;
    logic [31:0] data;
  } exp_t;

  logic clk0;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  exp_t qa0[$], qa1[$], qb0[$], qb1[$];
  int   qca[$], qcb[$];

  logic        a_rst, a_cs0, a_we0, a_cs1;
  logic [3:0]  a_wm0;
  logic [7:0]  a_ad0, a_ad1;
  logic [31:0] a_din0, a_dout0, a_dout1;
  logic        a_vld0, a_err0, a_vld1, a_err1, a_coll;

  logic        b_rst, b_cs0, b_we0, b_cs1;
  logic [3:0]  b_wm0;
  logic [7:0]  b_ad0, b_ad1;
  logic [31:0] b_din0, b_dout0, b_dout1;
  logic        b_vld0, b_err0, b_vld1, b_err1, b_coll;

  ram_1rw1r_model #(
    .DATA_WIDTH (32), .ADDR_WIDTH (8), .DEPTH (200),
    .WMASK_GRAN (8),  .READ_LAT (LAT_A), .RDW_MODE (0)
  ) dut_a (
    .clk0 (clk0), .rst0 (a_rst), .cs0 (a_cs0), .we0 (a_we0), .wmask0 (a_wm0),
    .addr0 (a_ad0), .din0 (a_din0), .dout0 (a_dout0), .dout0_vld (a_vld0),
    .err0 (a_err0), .cs1 (a_cs1), .addr1 (a_ad1), .dout1 (a_dout1),
    .dout1_vld (a_vld1), .err1 (a_err1), .collision (a_coll)
  );

  ram_1rw1r_model #(
    .DATA_WIDTH (32), .ADDR_WIDTH (8), .DEPTH (256),
    .WMASK_GRAN (8),  .READ_LAT (LAT_B), .RDW_MODE (1)
  ) dut_b (
    .clk0 (clk0), .rst0 (b_rst), .cs0 (b_cs0), .we0 (b_we0), .wmask0 (b_wm0),
    .addr0 (b_ad0), .din0 (b_din0), .dout0 (b_dout0), .dout0_vld (b_vld0),
    .err0 (b_err0), .cs1 (b_cs1), .addr1 (b_ad1), .dout1 (b_dout1),
    .dout1_vld (b_vld1), .err1 (b_err1), .collision (b_coll)
  );

  initial clk0 = 1'b0;
  always #5 clk0 = ~clk0;
  always @(posedge clk0) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", n, act, exp);
    end
  endtask

  task automatic chk_item(input string n, input exp_t e, input logic v, input logic er,
                          input logic [31:0] d);
    checks++;
    if (e.cyc != cyc || e.vld !== v || e.err !== er || (e.vld && e.data !== d)) begin
      errors++;
      $display("FAIL %s: got cyc=%0d vld=%0b err=%0b data=0x%08h, expected cyc=%0d vld=%0b err=%0b data=0x%08h",
               n, cyc, v, er, d, e.cyc, e.vld, e.err, e.data);
    end
  endtask

  // Expected results land LAT cycles after the negedge where the request is driven.
  task automatic ea0(input logic v, input logic er, input logic [31:0] d);
    qa0.push_back('{cyc: cyc + LAT_A, vld: v, err: er, data: d});
  endtask
  task automatic ea1(input logic v, input logic er, input logic [31:0] d);
    qa1.push_back('{cyc: cyc + LAT_A, vld: v, err: er, data: d});
  endtask
  task automatic eb0(input logic v, input logic er, input logic [31:0] d);
    qb0.push_back('{cyc: cyc + LAT_B, vld: v, err: er, data: d});
  endtask
  task automatic eb1(input logic v, input logic er, input logic [31:0] d);
    qb1.push_back('{cyc: cyc + LAT_B, vld: v, err: er, data: d});
  endtask
  task automatic eca();
    qca.push_back(cyc + 1);
  endtask
  task automatic ecb();
    qcb.push_back(cyc + 1);
  endtask

  task automatic a_op(input logic cs0, input logic we0, input logic [3:0] wm, input logic [7:0] ad0,
                      input logic [31:0] d0, input logic cs1, input logic [7:0] ad1);
    a_cs0 = cs0; a_we0 = we0; a_wm0 = wm; a_ad0 = ad0; a_din0 = d0; a_cs1 = cs1; a_ad1 = ad1;
    @(negedge clk0);
    a_cs0 = 1'b0; a_we0 = 1'b0; a_cs1 = 1'b0;
  endtask

  task automatic b_op(input logic cs0, input logic we0, input logic [3:0] wm, input logic [7:0] ad0,
                      input logic [31:0] d0, input logic cs1, input logic [7:0] ad1);
    b_cs0 = cs0; b_we0 = we0; b_wm0 = wm; b_ad0 = ad0; b_din0 = d0; b_cs1 = cs1; b_ad1 = ad1;
    @(negedge clk0);
    b_cs0 = 1'b0; b_we0 = 1'b0; b_cs1 = 1'b0;
  endtask

  // Monitor: every valid or error output must match the head of its queue.
  always @(negedge clk0) begin : mon
    exp_t e;
    int   c;
    if (a_vld0 || a_err0) begin
      if (qa0.size() > 0) e = qa0.pop_front();
      else e = '{cyc: -1, vld: 1'b0, err: 1'b0, data: 32'h0};
      chk_item("A_port0", e, a_vld0, a_err0, a_dout0);
    end
    if (a_vld1 || a_err1) begin
      if (qa1.size() > 0) e = qa1.pop_front();
      else e = '{cyc: -1, vld: 1'b0, err: 1'b0, data: 32'h0};
      chk_item("A_port1", e, a_vld1, a_err1, a_dout1);
    end
    if (b_vld0 || b_err0) begin
      if (qb0.size() > 0) e = qb0.pop_front();
      else e = '{cyc: -1, vld: 1'b0, err: 1'b0, data: 32'h0};
      chk_item("B_port0", e, b_vld0, b_err0, b_dout0);
    end
    if (b_vld1 || b_err1) begin
      if (qb1.size() > 0) e = qb1.pop_front();
      else e = '{cyc: -1, vld: 1'b0, err: 1'b0, data: 32'h0};
      chk_item("B_port1", e, b_vld1, b_err1, b_dout1);
    end
    if (a_coll) begin
      if (qca.size() > 0) c = qca.pop_front();
      else c = -1;
      chk("A_collision_cycle", 32'(cyc), 32'(c));
    end
    if (b_coll) begin
      if (qcb.size() > 0) c = qcb.pop_front();
      else c = -1;
      chk("B_collision_cycle", 32'(cyc), 32'(c));
    end
  end

  initial begin
    a_rst = 1'b1; a_cs0 = 1'b0; a_we0 = 1'b0; a_wm0 = '0; a_ad0 = '0; a_din0 = '0; a_cs1 = 1'b0; a_ad1 = '0;
    b_rst = 1'b1; b_cs0 = 1'b0; b_we0 = 1'b0; b_wm0 = '0; b_ad0 = '0; b_din0 = '0; b_cs1 = 1'b0; b_ad1 = '0;
    repeat (3) @(negedge clk0);
    chk("A_rst_dout0", a_dout0, 32'h0);
    chk("A_rst_dout1", a_dout1, 32'h0);
    chk("A_rst_flags", 32'({a_vld0, a_err0, a_vld1, a_err1, a_coll}), 32'h0);
    chk("B_rst_dout0", b_dout0, 32'h0);
    chk("B_rst_dout1", b_dout1, 32'h0);
    chk("B_rst_flags", 32'({b_vld0, b_err0, b_vld1, b_err1, b_coll}), 32'h0);
    a_rst = 1'b0; b_rst = 1'b0;

    // Instance B: full write/read, port-0 and port-1 same-address reads
    b_op(1, 1, 4'hF, 8'h10, 32'hDEAD_BEEF, 0, 8'h00);
    eb0(1, 0, 32'hDEAD_BEEF); b_op(1, 0, 4'h0, 8'h10, 32'h0, 0, 8'h00);
    eb0(1, 0, 32'hDEAD_BEEF); eb1(1, 0, 32'hDEAD_BEEF); b_op(1, 0, 4'h0, 8'h10, 32'h0, 1, 8'h10);
    // Lane-masked write
    b_op(1, 1, 4'hF, 8'h05, 32'h1122_3344, 0, 8'h00);
    b_op(1, 1, 4'h5, 8'h05, 32'hAABB_CCDD, 0, 8'h00);
    eb1(1, 0, 32'h11BB_33DD); b_op(0, 0, 4'h0, 8'h00, 32'h0, 1, 8'h05);
    // Collisions return merged new data
    b_op(1, 1, 4'hF, 8'h07, 32'h0, 0, 8'h00);
    eb1(1, 0, 32'hFFFF_FFFF); ecb(); b_op(1, 1, 4'hF, 8'h07, 32'hFFFF_FFFF, 1, 8'h07);
    b_op(1, 1, 4'hF, 8'h09, 32'h1234_5678, 0, 8'h00);
    eb1(1, 0, 32'h1234_AAAA); ecb(); b_op(1, 1, 4'h3, 8'h09, 32'hAAAA_AAAA, 1, 8'h09);
    b_op(1, 1, 4'h0, 8'h09, 32'h5555_5555, 0, 8'h00);
    // Back-to-back port-0 reads
    eb0(1, 0, 32'h11BB_33DD); b_op(1, 0, 4'h0, 8'h05, 32'h0, 0, 8'h00);
    eb0(1, 0, 32'hFFFF_FFFF); b_op(1, 0, 4'h0, 8'h07, 32'h0, 0, 8'h00);
    eb0(1, 0, 32'h1234_AAAA); eb1(1, 0, 32'h1234_AAAA); b_op(1, 0, 4'h0, 8'h09, 32'h0, 1, 8'h09);
    repeat (3) @(negedge clk0);
    chk("B_dout0_hold", b_dout0, 32'h1234_AAAA);
    chk("B_dout1_hold", b_dout1, 32'h1234_AAAA);

    // Instance A: collision returns pre-write data
    a_op(1, 1, 4'hF, 8'h07, 32'h0, 0, 8'h00);
    ea1(1, 0, 32'h0); eca(); a_op(1, 1, 4'hF, 8'h07, 32'hFFFF_FFFF, 1, 8'h07);
    ea1(1, 0, 32'hFFFF_FFFF); a_op(0, 0, 4'h0, 8'h00, 32'h0, 1, 8'h07);
    // Range boundary at DEPTH=200
    a_op(1, 1, 4'hF, 8'h48, 32'h55AA_55AA, 0, 8'h00);
    a_op(1, 1, 4'hF, 8'hC7, 32'hC7C7_C7C7, 0, 8'h00);
    ea0(1, 1, 32'h0); ea1(1, 1, 32'h0); a_op(1, 0, 4'h0, 8'hFF, 32'h0, 1, 8'hC8);
    ea0(0, 1, 32'h0); ea1(1, 1, 32'h0); a_op(1, 1, 4'hF, 8'hC8, 32'h1234_5678, 1, 8'hC8);
    ea0(1, 0, 32'h55AA_55AA); ea1(1, 0, 32'hC7C7_C7C7); a_op(1, 0, 4'h0, 8'h48, 32'h0, 1, 8'hC7);
    // Streaming reads at READ_LAT=3
    for (int i = 0; i < 10; i++) a_op(1, 1, 4'hF, 8'(i), 32'h100 + 32'(i), 0, 8'h00);
    for (int i = 0; i < 10; i++) begin
      ea1(1, 0, 32'h100 + 32'(i));
      a_op(0, 0, 4'h0, 8'h00, 32'h0, 1, 8'(i));
    end
    // A later write must not change an in-flight read
    ea1(1, 0, 32'h103); a_op(0, 0, 4'h0, 8'h00, 32'h0, 1, 8'h03);
    a_op(1, 1, 4'hF, 8'h03, 32'h0000_0BAD, 0, 8'h00);
    ea0(1, 0, 32'h0000_0BAD); a_op(1, 0, 4'h0, 8'h03, 32'h0, 0, 8'h00);
    repeat (5) @(negedge clk0);
    // Reset flushes in-flight reads and blocks a write presented under reset
    a_op(1, 0, 4'h0, 8'h01, 32'h0, 0, 8'h00);
    a_op(0, 0, 4'h0, 8'h00, 32'h0, 1, 8'h02);
    a_rst = 1'b1;
    a_op(1, 1, 4'hF, 8'h01, 32'hFFFF_0000, 1, 8'h01);
    @(negedge clk0);
    chk("A_rst2_dout0", a_dout0, 32'h0);
    chk("A_rst2_dout1", a_dout1, 32'h0);
    chk("A_rst2_flags", 32'({a_vld0, a_err0, a_vld1, a_err1, a_coll}), 32'h0);
    a_rst = 1'b0;
    repeat (4) @(negedge clk0);
    ea0(1, 0, 32'h101); ea1(1, 0, 32'h102); a_op(1, 0, 4'h0, 8'h01, 32'h0, 1, 8'h02);

    repeat (8) @(negedge clk0);
    chk("A0_drained", 32'(qa0.size()), 32'h0);
    chk("A1_drained", 32'(qa1.size()), 32'h0);
    chk("B0_drained", 32'(qb0.size()), 32'h0);
    chk("B1_drained", 32'(qb1.size()), 32'h0);
    chk("A_coll_drained", 32'(qca.size()), 32'h0);
    chk("B_coll_drained", 32'(qcb.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
